// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, line record and address-split helpers for the
// snooping word cache.
//   ADDR_WIDTH / DATA_WIDTH / LINES : default geometry of the cache
//   cache_line_t                    : {valid, tag, data} record for one line
//   get_index / get_tag             : split a byte address into line index and tag
// addr[0] selects a byte within a 16-bit word, so it never takes part in the lookup.
package cache_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 16;
    localparam int LINES      = 16;
    localparam int IW         = $clog2(LINES);
    localparam int TAG_WIDTH  = ADDR_WIDTH - IW - 1;

    typedef logic [IW-1:0]         index_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        logic                  valid;
        tag_t                  tag;
        logic [DATA_WIDTH-1:0] data;
    } cache_line_t;

    // Index comes from addr[IW:1]. Shift out the byte-select bit and truncate.
    function automatic index_t get_index(input addr_t addr);
        return index_t'(addr >> 1);
    endfunction

    // Tag comes from addr[ADDR_WIDTH-1:IW+1].
    function automatic tag_t get_tag(input addr_t addr);
        return tag_t'(addr >> (IW + 1));
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: LINES one-word cache lines.
//   clk, rst_n  : clock / asynchronous active-low reset (clears valid bits only)
//   i_rd_index  : asynchronous read index
//   o_rd_line   : {valid, tag, data} of the indexed line, combinational
//   i_wr_en     : write the line at i_wr_index on the rising edge
//   i_wr_index  : write index
//   i_wr_line   : line contents to store
// Tags and data carry no reset; they are meaningless while their valid bit is 0.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINES = cache_pkg::LINES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(LINES)-1:0] i_rd_index,
    output cache_line_t              o_rd_line,
    input  logic                     i_wr_en,
    input  logic [$clog2(LINES)-1:0] i_wr_index,
    input  cache_line_t              i_wr_line
);

    logic [LINES-1:0]      r_valid;
    tag_t                  r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= i_wr_line.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_line.tag;
            r_data[i_wr_index] <= i_wr_line.data;
        end
    end

    always_comb begin
        o_rd_line       = '0;
        o_rd_line.valid = r_valid[i_rd_index];
        o_rd_line.tag   = r_tag[i_rd_index];
        o_rd_line.data  = r_data[i_rd_index];
    end

endmodule

// File: rtl/cache_unit.sv
// cache_unit: direct-mapped, write-through, write-allocate word cache that
// snoops the shared CPU/RAM bus alongside the main RAM.
//   clk, rst_n     : clock / asynchronous active-low reset
//   addr           : byte address on the bus (MAR)
//   data           : shared tri-state data bus; driven only on a read hit
//   write_enable   : bus write cycle (wins when output_enable is also set)
//   output_enable  : bus read cycle
//   hit            : combinational read hit; the system uses it to deselect RAM
// The parameters must stay equal to the cache_pkg geometry, which fixes the
// line record layout and the address split.
module cache_unit #(
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int LINES      = cache_pkg::LINES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  write_enable,
    input  logic                  output_enable,
    output logic                  hit
);
    import cache_pkg::*;

    index_t      w_index;
    tag_t        w_tag;
    logic        w_read;
    logic        w_wr_en;
    cache_line_t w_rd_line;
    cache_line_t w_wr_line;

    assign w_index = get_index(addr);
    assign w_tag   = get_tag(addr);

    // A simultaneous write_enable turns the cycle into a write, never a read.
    assign w_read = output_enable && !write_enable;

    assign hit = w_read && w_rd_line.valid && (w_rd_line.tag == w_tag);

    // Only a hit puts the cache on the bus; every other cycle it stays high-Z.
    assign data = hit ? w_rd_line.data : {DATA_WIDTH{1'bz}};

    // Writes allocate; read misses fill from whatever RAM placed on the bus.
    // Either way the new line is captured from the bus at the rising edge.
    assign w_wr_en = write_enable || (w_read && !hit);

    always_comb begin
        w_wr_line       = '0;
        w_wr_line.valid = 1'b1;
        w_wr_line.tag   = w_tag;
        w_wr_line.data  = data;
    end

    cache_line_array #(
        .LINES (LINES)
    ) u_lines (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_index (w_index),
        .o_rd_line  (w_rd_line),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_index),
        .i_wr_line  (w_wr_line)
    );

endmodule

// File: tb/tb_cache_unit.sv
// tb_cache_unit: directed bench for cache_unit with a RAM model on the shared
// bus and a lookup-table model of the cache contents.
module tb_cache_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr;
    logic        we;
    logic        oe;
    logic        tb_bus_en;
    logic [15:0] tb_bus_val;
    wire  [15:0] data;
    wire         hit;

    always #5 clk = ~clk;

    // RAM side of the bus: drives write data, or read data when it is selected.
    assign data = tb_bus_en ? tb_bus_val : 16'hzzzz;

    cache_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .data          (data),
        .write_enable  (we),
        .output_enable (oe),
        .hit           (hit)
    );

    logic [15:0] ram [0:2047];
    int          m_tag  [int];
    logic [15:0] m_data [int];
    int          checks = 0;
    int          errors = 0;

    function automatic int m_idx(input logic [11:0] a);
        return (int'(a) / 2) % 16;
    endfunction

    function automatic int m_tg(input logic [11:0] a);
        return int'(a) / 32;
    endfunction

    function automatic bit mhit(input logic [11:0] a, input logic o, input logic w);
        int i;
        i = m_idx(a);
        return o && !w && m_tag.exists(i) && (m_tag[i] == m_tg(a));
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t addr=%h: got %h, expected %h", nm, $time, addr, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        bit eh;
        if (rst_n) begin
            eh = mhit(addr, oe, we);
            check("hit_vs_model", {15'd0, hit}, {15'd0, eh});
            if (eh)
                check("hit_data_vs_model", data, m_data[m_idx(addr)]);
            else if (tb_bus_en)
                check("bus_not_driven", data, tb_bus_val);
        end
    end

    // Model / RAM update at the edge that ends each cycle.
    always @(posedge clk) begin
        if (rst_n) begin
            if (we) begin
                m_tag[m_idx(addr)]  = m_tg(addr);
                m_data[m_idx(addr)] = tb_bus_val;
                ram[int'(addr) / 2] = tb_bus_val;
            end else if (oe && !mhit(addr, oe, we)) begin
                m_tag[m_idx(addr)]  = m_tg(addr);
                m_data[m_idx(addr)] = tb_bus_val;
            end
        end
    end

    task automatic do_read(input logic [11:0] a);
        @(posedge clk); #2;
        addr = a; we = 1'b0; oe = 1'b1;
        if (mhit(a, 1'b1, 1'b0)) begin
            tb_bus_en = 1'b0;
        end else begin
            tb_bus_en  = 1'b1;
            tb_bus_val = ram[int'(a) / 2];
        end
        #1;
        $display("%0t READ  addr=%h hit=%0b data=%h", $time, a, hit, data);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] v, input logic with_oe);
        @(posedge clk); #2;
        addr = a; we = 1'b1; oe = with_oe;
        tb_bus_en = 1'b1; tb_bus_val = v;
        #1;
        $display("%0t WRITE addr=%h oe=%0b bus=%h hit=%0b", $time, a, with_oe, data, hit);
    endtask

    task automatic do_idle();
        @(posedge clk); #2;
        we = 1'b0; oe = 1'b0; tb_bus_en = 1'b0;
        #1;
        $display("%0t IDLE  hit=%0b", $time, hit);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 16'(i * 7 + 16'h5A00);
        ram[12'h100 / 2] = 16'h111C;
        ram[12'h11E / 2] = 16'hBEEF;
        ram[12'h122 / 2] = 16'h0123;

        rst_n = 1'b0; addr = '0; we = 1'b0; oe = 1'b0;
        tb_bus_en = 1'b0; tb_bus_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hit", {15'd0, hit}, 16'd0);
        #1 rst_n = 1'b1;
        $display("%0t RESET released", $time);

        // Cold miss, fill from RAM, then hit.
        do_read(12'h100);
        check("cold_miss_hit", {15'd0, hit}, 16'd0);
        check("cold_miss_bus", data, 16'h111C);
        do_read(12'h100);
        check("refill_hit", {15'd0, hit}, 16'd1);
        check("refill_data", data, 16'h111C);

        // Write-allocate then read back.
        do_write(12'h11C, 16'h0001, 1'b0);
        check("write_hit", {15'd0, hit}, 16'd0);
        check("write_bus", data, 16'h0001);
        do_read(12'h11C);
        check("wa_hit", {15'd0, hit}, 16'd1);
        check("wa_data", data, 16'h0001);

        // Conflict at index 0.
        do_write(12'h100, 16'h111C, 1'b0);
        do_write(12'h120, 16'h1001, 1'b0);
        do_read(12'h120);
        check("conflict_new_hit", {15'd0, hit}, 16'd1);
        check("conflict_new_data", data, 16'h1001);
        do_read(12'h100);
        check("conflict_old_miss", {15'd0, hit}, 16'd0);
        check("conflict_old_bus", data, 16'h111C);

        // Held address for three cycles.
        do_read(12'h11E);
        check("hold1_hit", {15'd0, hit}, 16'd0);
        do_read(12'h11E);
        check("hold2_hit", {15'd0, hit}, 16'd1);
        check("hold2_data", data, 16'hBEEF);
        do_read(12'h11E);
        check("hold3_hit", {15'd0, hit}, 16'd1);
        check("hold3_data", data, 16'hBEEF);

        // Both enables: write wins.
        do_write(12'h122, 16'hFFFF, 1'b1);
        check("we_oe_hit", {15'd0, hit}, 16'd0);
        check("we_oe_bus", data, 16'hFFFF);
        do_read(12'h122);
        check("we_oe_readback_hit", {15'd0, hit}, 16'd1);
        check("we_oe_readback_data", data, 16'hFFFF);
        do_idle();
        check("idle_hit", {15'd0, hit}, 16'd0);

        // Fill every index, then reset in the middle of a hitting read.
        for (int i = 0; i < 16; i++) do_read(12'(12'h100 + 2 * i));
        do_read(12'h104);
        check("pre_reset_hit", {15'd0, hit}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_hit", {15'd0, hit}, 16'd0);
        m_tag.delete();
        m_data.delete();
        we = 1'b0; oe = 1'b0; tb_bus_en = 1'b0;
        $display("%0t RESET asserted mid-read", $time);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        $display("%0t RESET released", $time);
        for (int i = 0; i < 16; i++) begin
            do_read(12'(12'h100 + 2 * i));
            check("post_reset_miss", {15'd0, hit}, 16'd0);
        end
        do_idle();
        do_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
